// File: rtl/mmio_io_responder_if.sv
// Data-memory bus slice steered to the I/O window: single-cycle strobes and
// a registered read response.
interface mmio_io_responder_if #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned data_width = 32
) ();
    logic                  wr_en;
    logic                  rd_en;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wr_data;
    logic [data_width-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output wr_en, rd_en, addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/mmio_io_responder.sv
// I/O window responder: two write/readback 7-segment registers and a
// debounced button status word with sticky press flags (cleared on read).
module mmio_io_responder #(
    parameter int unsigned          addr_width      = 10,
    parameter int unsigned          data_width      = 32,
    parameter logic [addr_width-1:0] SEG0_ADDR      = 10'h3FF,
    parameter logic [addr_width-1:0] SEG1_ADDR      = 10'h3FE,
    parameter logic [addr_width-1:0] BTN_ADDR       = 10'h3EF,
    parameter int unsigned          NUM_BTN         = 4,
    parameter int unsigned          DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    mmio_io_responder_if.slave bus,
    output logic [7:0]         seg0,
    output logic [7:0]         seg1,
    input  logic [NUM_BTN-1:0] btn_in
);

    localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]            seg0_q, seg1_q;
    logic [data_width-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [NUM_BTN-1:0]    sync1_q, sync2_q;
    logic [NUM_BTN-1:0]    deb_q, deb_d;
    logic [NUM_BTN-1:0]    sticky_q, sticky_d;
    logic [CntW-1:0]       cnt_q [NUM_BTN];
    logic [CntW-1:0]       cnt_d [NUM_BTN];

    logic rd_req, btn_rd;
    logic unused_wr_data;

    // A simultaneous write strobe suppresses the read.
    assign rd_req         = bus.rd_en & ~bus.wr_en;
    assign btn_rd         = rd_req && (bus.addr == BTN_ADDR);
    assign unused_wr_data = ^bus.wr_data[data_width-1:8];

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
        // Set wins over the clear-on-read.
        sticky_d = (btn_rd ? '0 : sticky_q) | (deb_d & ~deb_q);
    end

    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        if (rd_req) begin
            if (bus.addr == SEG0_ADDR) begin
                rd_valid_d     = 1'b1;
                rd_data_d[7:0] = seg0_q;
            end else if (bus.addr == SEG1_ADDR) begin
                rd_valid_d     = 1'b1;
                rd_data_d[7:0] = seg1_q;
            end else if (bus.addr == BTN_ADDR) begin
                rd_valid_d               = 1'b1;
                rd_data_d[NUM_BTN-1:0]   = deb_q;
                rd_data_d[16 +: NUM_BTN] = sticky_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg0_q     <= '0;
            seg1_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (bus.wr_en && (bus.addr == SEG0_ADDR)) seg0_q <= bus.wr_data[7:0];
            if (bus.wr_en && (bus.addr == SEG1_ADDR)) seg1_q <= bus.wr_data[7:0];
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            sticky_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign seg0         = seg0_q;
    assign seg1         = seg1_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
